clock_set_ctrl: RTL

- Front-panel controller that sequences the clock's time-setting datapath.
- Consumes debounced MODE/ADD key levels and a 10 ms tick.
- Produces the display/edit status, single-cycle increment strobes to the hour/minute/month/day counters, a seconds run-enable/clear, and a blink-masked digit enable for the segment scanner.
- Adds auto-repeat on held ADD and an idle timeout back to time display.

---
 rtl/clock_set_ctrl_if.sv | 27 ++
 rtl/clock_set_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/clock_set_ctrl_if.sv
// Front-panel bundle between the key/tick source and the clock-set controller.
// master = panel side (keys, tick); slave = controller side (status, strobes, display enables).
interface clock_set_ctrl_if;
  logic       tick_10ms;
  logic       mode_key;
  logic       add_key;
  logic [2:0] status;
  logic       inc_hour;
  logic       inc_minute;
  logic       inc_month;
  logic       inc_day;
  logic       run_enable;
  logic       sec_clear;
  logic [3:0] digit_enable;

  modport master (
    output tick_10ms, mode_key, add_key,
    input  status, inc_hour, inc_minute, inc_month, inc_day,
           run_enable, sec_clear, digit_enable
  );

  modport slave (
    input  tick_10ms, mode_key, add_key,
    output status, inc_hour, inc_minute, inc_month, inc_day,
           run_enable, sec_clear, digit_enable
  );
endinterface

// File: rtl/clock_set_ctrl.sv
// Time-setting sequencer: MODE walks the set states, ADD strobes the selected field
// with auto-repeat, idle timeout returns to time display, blinking field mask.
module clock_set_ctrl #(
  parameter int REPEAT_DELAY = 50,
  parameter int REPEAT_RATE  = 10,
  parameter int TIMEOUT      = 1000,
  parameter int BLINK_HALF   = 25
) (
  input logic             clock,
  input logic             reset,
  clock_set_ctrl_if.slave bus
);
  localparam int REP_W = $clog2(REPEAT_DELAY + 1);
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam int BL_W  = $clog2(BLINK_HALF + 1);

  localparam logic [2:0] ST_TIME = 3'd0;
  localparam logic [2:0] ST_HOUR = 3'd1;
  localparam logic [2:0] ST_MIN  = 3'd2;
  localparam logic [2:0] ST_MON  = 3'd3;
  localparam logic [2:0] ST_DAY  = 3'd4;

  logic [2:0]      status_q, status_d;
  logic            mode_q, mode_prev_q, add_q, add_prev_q;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic [BL_W-1:0] blink_cnt_q, blink_cnt_d;
  logic            blink_on_q, blink_on_d;
  logic            edited_q, edited_d;
  logic            add_armed_q, add_armed_d;
  logic [3:0]      inc_q, inc_d;
  logic            run_en_q, run_en_d;
  logic            sec_clear_q, sec_clear_d;
  logic [3:0]      digit_en_q, digit_en_d;

  logic mode_edge_s, add_edge_s, in_set_s, expire_s, state_change_s, strobe_s, enter_time_s;

  function automatic logic [3:0] field_mask(input logic [2:0] st);
    case (st)
      ST_HOUR, ST_MON: field_mask = 4'b1100;
      ST_MIN, ST_DAY:  field_mask = 4'b0011;
      default:         field_mask = 4'b1111;
    endcase
  endfunction

  assign mode_edge_s    = mode_q & ~mode_prev_q;
  assign add_edge_s     = add_q & ~add_prev_q;
  assign in_set_s       = (status_q != ST_TIME);
  assign state_change_s = mode_edge_s | expire_s;
  assign enter_time_s   = state_change_s & (status_d == ST_TIME);

  // State register, including key history and all registered outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      status_q    <= ST_TIME;
      mode_q      <= 1'b0;
      mode_prev_q <= 1'b0;
      add_q       <= 1'b0;
      add_prev_q  <= 1'b0;
      to_cnt_q    <= '0;
      rep_cnt_q   <= '0;
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
      edited_q    <= 1'b0;
      add_armed_q <= 1'b0;
      inc_q       <= 4'b0000;
      run_en_q    <= 1'b1;
      sec_clear_q <= 1'b0;
      digit_en_q  <= 4'b1111;
    end else begin
      status_q    <= status_d;
      mode_q      <= bus.mode_key;
      mode_prev_q <= mode_q;
      add_q       <= bus.add_key;
      add_prev_q  <= add_q;
      to_cnt_q    <= to_cnt_d;
      rep_cnt_q   <= rep_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
      edited_q    <= edited_d;
      add_armed_q <= add_armed_d;
      inc_q       <= inc_d;
      run_en_q    <= run_en_d;
      sec_clear_q <= sec_clear_d;
      digit_en_q  <= digit_en_d;
    end
  end

  // Next status and idle timeout; a MODE edge takes priority over expiry.
  always_comb begin
    status_d = status_q;
    to_cnt_d = to_cnt_q;
    expire_s = 1'b0;
    if (in_set_s && bus.tick_10ms && !mode_q && !add_q && (to_cnt_q == TO_W'(TIMEOUT - 1))) begin
      expire_s = 1'b1;
    end else begin
      expire_s = 1'b0;
    end
    if (mode_edge_s) begin
      case (status_q)
        ST_TIME: status_d = ST_HOUR;
        ST_HOUR: status_d = ST_MIN;
        ST_MIN:  status_d = ST_MON;
        ST_MON:  status_d = ST_DAY;
        ST_DAY:  status_d = ST_TIME;
        default: status_d = ST_TIME;
      endcase
    end else if (expire_s) begin
      status_d = ST_TIME;
    end else begin
      status_d = status_q;
    end
    if (state_change_s || !in_set_s || mode_q || add_q) begin
      to_cnt_d = '0;
    end else if (bus.tick_10ms && (to_cnt_q != TO_W'(TIMEOUT))) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end else begin
      to_cnt_d = to_cnt_q;
    end
  end

  // Strobes with auto-repeat, run control and blink-masked digit enables.
  always_comb begin
    rep_cnt_d   = rep_cnt_q;
    add_armed_d = add_armed_q;
    strobe_s    = 1'b0;
    inc_d       = 4'b0000;
    edited_d    = edited_q;
    run_en_d    = run_en_q;
    sec_clear_d = 1'b0;
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    digit_en_d  = 4'b1111;

    // A MODE change disarms ADD so a held key never repeats into the next field.
    if (!add_q || state_change_s) begin
      rep_cnt_d   = '0;
      add_armed_d = 1'b0;
    end else if (add_edge_s && in_set_s) begin
      strobe_s    = 1'b1;
      add_armed_d = 1'b1;
      rep_cnt_d   = '0;
    end else if (add_armed_q && bus.tick_10ms) begin
      if (rep_cnt_q == REP_W'(REPEAT_DELAY - 1)) begin
        strobe_s  = 1'b1;
        rep_cnt_d = REP_W'(REPEAT_DELAY - REPEAT_RATE);
      end else begin
        rep_cnt_d = rep_cnt_q + REP_W'(1);
      end
    end else begin
      rep_cnt_d = rep_cnt_q;
    end

    if (strobe_s) begin
      case (status_q)
        ST_HOUR: inc_d = 4'b0001;
        ST_MIN:  inc_d = 4'b0010;
        ST_MON:  inc_d = 4'b0100;
        ST_DAY:  inc_d = 4'b1000;
        default: inc_d = 4'b0000;
      endcase
    end else begin
      inc_d = 4'b0000;
    end

    if (enter_time_s) begin
      sec_clear_d = edited_q;
      run_en_d    = 1'b1;
      edited_d    = 1'b0;
    end else if (strobe_s) begin
      run_en_d = 1'b0;
      edited_d = 1'b1;
    end else begin
      run_en_d = run_en_q;
      edited_d = edited_q;
    end

    if (state_change_s || strobe_s || !in_set_s) begin
      blink_cnt_d = '0;
      blink_on_d  = 1'b1;
    end else if (bus.tick_10ms) begin
      if (blink_cnt_q == BL_W'(BLINK_HALF - 1)) begin
        blink_cnt_d = '0;
        blink_on_d  = ~blink_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BL_W'(1);
      end
    end else begin
      blink_cnt_d = blink_cnt_q;
    end

    if (status_d == ST_TIME) begin
      digit_en_d = 4'b1111;
    end else if (blink_on_d || add_q) begin
      digit_en_d = field_mask(status_d);
    end else begin
      digit_en_d = 4'b0000;
    end
  end

  assign bus.status       = status_q;
  assign bus.inc_hour     = inc_q[0];
  assign bus.inc_minute   = inc_q[1];
  assign bus.inc_month    = inc_q[2];
  assign bus.inc_day      = inc_q[3];
  assign bus.run_enable   = run_en_q;
  assign bus.sec_clear    = sec_clear_q;
  assign bus.digit_enable = digit_en_q;
endmodule
